// File: rtl/tx_seq_recorder_nch_pkg.sv
// Shared types and constants for the TL TX arrival-order recorder.
// Channel numbering and ordering-mode encoding used by the TX arbiter.
package tx_seq_recorder_nch_pkg;

    localparam int MAX_CH = 8;

    localparam int CH_A2P_RD     = 0;
    localparam int CH_A2P_WR     = 1;
    localparam int CH_MASTER_CPL = 2;
    localparam int CH_RX_ROUTER  = 3;

    typedef logic [$clog2(MAX_CH)-1:0] chan_id_t;

    typedef enum logic {
        PRIO_FIXED = 1'b0,
        PRIO_RR    = 1'b1
    } prio_mode_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_seq_recorder_nch_order_scan.sv
// Same-cycle arrival scan: walks the channels from a start index,
// grants the first 'free' requesters and lists their IDs in scan order.
module tx_seq_order_scan
    import tx_seq_recorder_nch_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 5,
    parameter int ID_W   = id_width(N_CH),
    parameter int NACC_W = $clog2(N_CH + 1)
) (
    input  logic [N_CH-1:0]           req_valid,
    input  logic [ID_W-1:0]           start,
    input  logic [CNT_W-1:0]          free,
    output logic [N_CH-1:0]           req_ready,
    output logic [NACC_W-1:0]         n_acc,
    output logic [N_CH-1:0][ID_W-1:0] order_ids,
    output logic [ID_W-1:0]           last_id
);

    int ch;
    int ahead;
    int acc;

    // A channel is ready while free space exceeds the requesters scanned before it.
    always_comb begin
        req_ready = '0;
        order_ids = '0;
        n_acc     = '0;
        last_id   = '0;
        ch        = 0;
        ahead     = 0;
        acc       = 0;
        for (int k = 0; k < N_CH; k++) begin
            ch = int'(start) + k;
            if (ch >= N_CH) ch = ch - N_CH;
            if (int'(free) > ahead) req_ready[ID_W'(ch)] = 1'b1;
            if (req_valid[ID_W'(ch)]) begin
                if (int'(free) > ahead) begin
                    order_ids[ID_W'(acc)] = ID_W'(ch);
                    last_id = ID_W'(ch);
                    acc = acc + 1;
                end
                ahead = ahead + 1;
            end
        end
        n_acc = NACC_W'(acc);
    end

endmodule

// File: rtl/tx_seq_recorder_nch.sv
// TLP arrival-order recorder: multi-write, single-read FIFO of channel IDs
// with head/next-to-head lookahead for the TX arbiter.
module tx_seq_recorder_nch
    import tx_seq_recorder_nch_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int PRIO_MODE  = 0,
    parameter int AF_THRESH  = 12,
    localparam int ID_W      = id_width(N_CH),
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             flush,
    input  logic [N_CH-1:0]  req_valid,
    output logic [N_CH-1:0]  req_ready,
    input  logic             rd_en,
    output logic             head_valid,
    output logic [ID_W-1:0]  head_id,
    output logic             head2_valid,
    output logic [ID_W-1:0]  head2_id,
    output logic [CNT_W-1:0] count,
    output logic             almost_full,
    output logic             overflow_err
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int NACC_W = $clog2(N_CH + 1);
    localparam bit RR_EN  = (PRIO_MODE == int'(PRIO_RR));

    logic [ID_W-1:0]           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          cnt_q;
    logic [ID_W-1:0]           rr_ptr;
    logic                      ovf_q;

    logic [CNT_W-1:0]          free;
    logic [ID_W-1:0]           start;
    logic [N_CH-1:0]           scan_ready;
    logic [NACC_W-1:0]         scan_n_acc;
    logic [N_CH-1:0][ID_W-1:0] scan_ids;
    logic [ID_W-1:0]           scan_last;
    logic                      blocked;
    logic [NACC_W-1:0]         n_acc;
    logic                      pop;

    // Space is taken from the registered count so req_ready never depends on rd_en.
    assign free    = CNT_W'(FIFO_DEPTH) - cnt_q;
    assign start   = RR_EN ? rr_ptr : '0;
    assign blocked = arst | flush;

    tx_seq_order_scan #(
        .N_CH   (N_CH),
        .CNT_W  (CNT_W),
        .ID_W   (ID_W),
        .NACC_W (NACC_W)
    ) u_scan (
        .req_valid (req_valid),
        .start     (start),
        .free      (free),
        .req_ready (scan_ready),
        .n_acc     (scan_n_acc),
        .order_ids (scan_ids),
        .last_id   (scan_last)
    );

    assign req_ready    = blocked ? '0 : scan_ready;
    assign n_acc        = blocked ? '0 : scan_n_acc;
    assign head_valid   = (cnt_q != '0);
    assign head2_valid  = (cnt_q >= CNT_W'(2));
    assign pop          = rd_en & head_valid;
    assign head_id      = mem[rd_ptr];
    assign head2_id     = mem[rd_ptr + PTR_W'(1)];
    assign count        = cnt_q;
    assign almost_full  = (cnt_q >= CNT_W'(AF_THRESH));
    assign overflow_err = ovf_q;

    // Pointers, occupancy, round-robin start and sticky empty-pop flag.
    always_ff @(posedge clk) begin
        if (arst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            rr_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_acc);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            cnt_q  <= cnt_q + CNT_W'(n_acc) - CNT_W'(pop);
            if (rd_en && !head_valid) ovf_q <= 1'b1;
            if (RR_EN && n_acc != '0) begin
                rr_ptr <= (int'(scan_last) == N_CH - 1) ? '0 : scan_last + ID_W'(1);
            end
        end
    end

    // Accepted IDs land in consecutive slots from wr_ptr in scan order.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (i < int'(n_acc)) mem[wr_ptr + PTR_W'(i)] <= scan_ids[i];
        end
    end

endmodule
